mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer sharing one single-port memory between instruction fetch (port 0) and load/store (port 1) in the multi-cycle core. It accepts one request at a time through valid/ready handshakes, issues it to the memory, waits for the memory's acknowledge, and returns read data to the owner. It uses round-robin fairness and a per-transaction timeout.

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port memory between instruction fetch
// (port 0) and load/store (port 1), with round-robin ties and a WAIT timeout.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-low reset
//   pN_req_valid/ready  request handshake from port N (ready combinational)
//   pN_addr/wen/wdata/wmask  request fields, sampled only on acceptance
//   pN_resp_valid/err   one-cycle response pulse and timeout flag to port N
//   resp_rdata          read data shared by both ports
//   mem_valid/ready     request handshake toward the memory
//   mem_addr/wen/wdata/wmask  latched request fields toward the memory
//   mem_rvalid/rdata    memory completion (read data valid / write ack)
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                p0_req_valid,
    output logic                p0_req_ready,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic                p0_wen,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wmask,
    output logic                p0_resp_valid,
    output logic                p0_resp_err,

    input  logic                p1_req_valid,
    output logic                p1_req_ready,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic                p1_wen,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wmask,
    output logic                p1_resp_valid,
    output logic                p1_resp_err,

    output logic [DATA_W-1:0]   resp_rdata,

    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_last_grant;
    logic                r_owner;
    logic [15:0]         r_cnt;

    logic                r_mem_valid;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_wen;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [MASK_W-1:0]   r_mem_wmask;

    logic [DATA_W-1:0]   r_rdata;
    logic                r_resp_valid0;
    logic                r_resp_valid1;
    logic                r_resp_err0;
    logic                r_resp_err1;

    logic                w_idle;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_acc0;
    logic                w_acc1;
    logic                w_accept;
    logic                w_in_issue;
    logic                w_in_wait;
    logic                w_done_ok;
    logic                w_done_to;
    logic                w_done;
    logic                w_mem_valid_nxt;

    // On a tie the port that did not win last time is granted; a lone
    // valid port always wins.
    always_comb begin
        w_gnt0 = p0_req_valid & (~p1_req_valid | r_last_grant);
        w_gnt1 = p1_req_valid & (~p0_req_valid | ~r_last_grant);
    end

    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_in_issue = (r_state == ST_ISSUE);
        w_in_wait  = (r_state == ST_WAIT);
        w_acc0     = w_idle & w_gnt0;
        w_acc1     = w_idle & w_gnt1;
        w_accept   = w_acc0 | w_acc1;
        // A completion always beats a timeout landing in the same cycle.
        w_done_ok  = w_in_wait & mem_rvalid;
        w_done_to  = w_in_wait & ~mem_rvalid & (r_cnt == TO_LAST);
        w_done     = w_done_ok | w_done_to;
        w_mem_valid_nxt = w_accept | (w_in_issue & ~mem_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_cnt         <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wen     <= 1'b0;
            r_mem_wdata   <= '0;
            r_mem_wmask   <= '0;
            r_rdata       <= '0;
            r_resp_valid0 <= 1'b0;
            r_resp_valid1 <= 1'b0;
            r_resp_err0   <= 1'b0;
            r_resp_err1   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_acc1;
                r_last_grant <= w_acc1;
                r_mem_addr   <= w_acc1 ? p1_addr  : p0_addr;
                r_mem_wen    <= w_acc1 ? p1_wen   : p0_wen;
                r_mem_wdata  <= w_acc1 ? p1_wdata : p0_wdata;
                r_mem_wmask  <= w_acc1 ? p1_wmask : p0_wmask;
            end

            r_mem_valid <= w_mem_valid_nxt;

            // Cleared while issuing so the first WAIT cycle sees zero.
            if (w_in_issue) begin
                r_cnt <= '0;
            end else if (w_in_wait) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_done_ok) begin
                r_rdata <= mem_rdata;
            end else if (w_done_to) begin
                r_rdata <= '0;
            end

            r_resp_valid0 <= w_done & ~r_owner;
            r_resp_valid1 <= w_done & r_owner;
            r_resp_err0   <= w_done_to & ~r_owner;
            r_resp_err1   <= w_done_to & r_owner;
        end
    end

    assign p0_req_ready  = w_acc0;
    assign p1_req_ready  = w_acc1;
    assign p0_resp_valid = r_resp_valid0;
    assign p1_resp_valid = r_resp_valid1;
    assign p0_resp_err   = r_resp_err0;
    assign p1_resp_err   = r_resp_err1;
    assign resp_rdata    = r_rdata;
    assign mem_valid     = r_mem_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wmask     = r_mem_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for read/contention,
// hand sequences for write stall, timeout, timeout tie and reset in WAIT.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        p0_req_valid = 0, p1_req_valid = 0;
    logic        p0_req_ready, p1_req_ready;
    logic [31:0] p0_addr = 0, p1_addr = 0;
    logic        p0_wen = 0, p1_wen = 0;
    logic [31:0] p0_wdata = 0, p1_wdata = 0;
    logic [3:0]  p0_wmask = 0, p1_wmask = 0;
    logic        p0_resp_valid, p1_resp_valid;
    logic        p0_resp_err, p1_resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid;
    logic        mem_ready = 0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;

    int n_tot = 0;
    int n_bad = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_addr(p0_addr), .p0_wen(p0_wen),
        .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_resp_valid(p0_resp_valid), .p0_resp_err(p0_resp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_addr(p1_addr), .p1_wen(p1_wen),
        .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_resp_valid(p1_resp_valid), .p1_resp_err(p1_resp_err),
        .resp_rdata(resp_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        p0v;
        logic        p1v;
        logic        mrdy;
        logic        mrv;
        logic [31:0] mrdata;
        logic        e_r0;
        logic        e_r1;
        logic        e_mv;
        logic        e_v0;
        logic        e_v1;
        logic        e_e0;
        logic        e_e1;
        logic [31:0] e_addr;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string nm, input logic v0, input logic v1);
        chk({nm, "_v0"}, 32'(p0_resp_valid), 32'(v0));
        chk({nm, "_v1"}, 32'(p1_resp_valid), 32'(v1));
    endtask

    initial begin
        //         rst p0 p1 rdy rv mrdata        r0 r1 mv v0 v1 e0 e1 addr          rdata
        tbl[0]  = '{1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0};
        tbl[1]  = '{1, 1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0};
        tbl[2]  = '{1, 0, 0, 1, 0, 32'h0,        0, 0, 1, 0, 0, 0, 0, 32'h10,  32'h0};
        tbl[3]  = '{1, 0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 32'h10,  32'h0};
        tbl[4]  = '{1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 32'h10,  32'h12345678};
        tbl[5]  = '{1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h10,  32'h12345678};
        tbl[6]  = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h10,  32'h12345678};
        tbl[7]  = '{1, 1, 1, 1, 1, 32'hA0,       1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0};
        tbl[8]  = '{1, 1, 1, 1, 1, 32'hA1,       0, 0, 1, 0, 0, 0, 0, 32'h10,  32'h0};
        tbl[9]  = '{1, 1, 1, 1, 1, 32'hA2,       0, 0, 0, 0, 0, 0, 0, 32'h10,  32'h0};
        tbl[10] = '{1, 1, 1, 1, 1, 32'hA3,       0, 0, 0, 1, 0, 0, 0, 32'h10,  32'hA2};
        tbl[11] = '{1, 1, 1, 1, 1, 32'hB0,       0, 1, 0, 0, 0, 0, 0, 32'h10,  32'hA2};
        tbl[12] = '{1, 1, 1, 1, 1, 32'hB1,       0, 0, 1, 0, 0, 0, 0, 32'h300, 32'hA2};
        tbl[13] = '{1, 1, 1, 1, 1, 32'hB3,       0, 0, 0, 0, 0, 0, 0, 32'h300, 32'hA2};
        tbl[14] = '{1, 1, 1, 1, 1, 32'hB4,       0, 0, 0, 0, 1, 0, 0, 32'h300, 32'hB3};
        tbl[15] = '{1, 1, 1, 1, 1, 32'hC0,       1, 0, 0, 0, 0, 0, 0, 32'h300, 32'hB3};
        tbl[16] = '{1, 1, 1, 1, 1, 32'hC1,       0, 0, 1, 0, 0, 0, 0, 32'h10,  32'hB3};
        tbl[17] = '{1, 1, 1, 1, 1, 32'hC5,       0, 0, 0, 0, 0, 0, 0, 32'h10,  32'hB3};
        tbl[18] = '{1, 1, 1, 1, 1, 32'hC6,       0, 0, 0, 1, 0, 0, 0, 32'h10,  32'hC5};
        tbl[19] = '{1, 1, 1, 1, 1, 32'hD0,       0, 1, 0, 0, 0, 0, 0, 32'h10,  32'hC5};
        tbl[20] = '{1, 0, 0, 1, 1, 32'hD1,       0, 0, 1, 0, 0, 0, 0, 32'h300, 32'hC5};
        tbl[21] = '{1, 0, 0, 1, 1, 32'hD7,       0, 0, 0, 0, 0, 0, 0, 32'h300, 32'hC5};
        tbl[22] = '{1, 0, 0, 1, 1, 32'hD8,       0, 0, 0, 0, 1, 0, 0, 32'h300, 32'hD7};
        tbl[23] = '{1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h300, 32'hD7};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        p0_addr = 32'h10;
        p1_addr = 32'h300;

        for (int i = 0; i < 24; i++) begin
            rst          = tbl[i].rst;
            p0_req_valid = tbl[i].p0v;
            p1_req_valid = tbl[i].p1v;
            mem_ready    = tbl[i].mrdy;
            mem_rvalid   = tbl[i].mrv;
            mem_rdata    = tbl[i].mrdata;
            @(negedge clk);
            chk($sformatf("v%0d_rdy0", i), 32'(p0_req_ready), 32'(tbl[i].e_r0));
            chk($sformatf("v%0d_rdy1", i), 32'(p1_req_ready), 32'(tbl[i].e_r1));
            chk($sformatf("v%0d_mval", i), 32'(mem_valid), 32'(tbl[i].e_mv));
            chk($sformatf("v%0d_rv0", i), 32'(p0_resp_valid), 32'(tbl[i].e_v0));
            chk($sformatf("v%0d_rv1", i), 32'(p1_resp_valid), 32'(tbl[i].e_v1));
            chk($sformatf("v%0d_err0", i), 32'(p0_resp_err), 32'(tbl[i].e_e0));
            chk($sformatf("v%0d_err1", i), 32'(p1_resp_err), 32'(tbl[i].e_e1));
            chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_rdata", i), resp_rdata, tbl[i].e_rdata);
            cyc();
        end

        // write from p1 with three stall cycles
        p1_req_valid = 1; p1_addr = 32'h100; p1_wen = 1;
        p1_wdata = 32'hCAFEF00D; p1_wmask = 4'b0011;
        mem_ready = 0; mem_rvalid = 0;
        @(negedge clk);
        chk("wr_rdy1", 32'(p1_req_ready), 32'd1);
        chk("wr_rdy0", 32'(p0_req_ready), 32'd0);
        cyc();
        p1_req_valid = 0; p1_addr = 32'hFFFFFFFF;
        p1_wdata = 32'h0; p1_wmask = 4'hF; p1_wen = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            chk($sformatf("wr_is%0d_mval", i), 32'(mem_valid), 32'd1);
            chk($sformatf("wr_is%0d_addr", i), mem_addr, 32'h100);
            chk($sformatf("wr_is%0d_wen", i), 32'(mem_wen), 32'd1);
            chk($sformatf("wr_is%0d_wdata", i), mem_wdata, 32'hCAFEF00D);
            chk($sformatf("wr_is%0d_wmask", i), 32'(mem_wmask), 32'h3);
            cyc();
        end
        mem_ready = 0;
        @(negedge clk);
        chk("wr_w0_mval", 32'(mem_valid), 32'd0);
        chk_resp("wr_w0", 0, 0);
        cyc();
        mem_rvalid = 1; mem_rdata = 32'h55;
        @(negedge clk);
        chk_resp("wr_w1", 0, 0);
        cyc();
        mem_rvalid = 0;
        @(negedge clk);
        chk_resp("wr_resp", 0, 1);
        chk("wr_err1", 32'(p1_resp_err), 32'd0);
        cyc();
        @(negedge clk);
        chk_resp("wr_after", 0, 0);
        cyc();

        // timeout with no completion, then a stray ack
        p0_req_valid = 1; p0_addr = 32'h40; p0_wen = 0;
        @(negedge clk);
        chk("to_rdy0", 32'(p0_req_ready), 32'd1);
        cyc();
        p0_req_valid = 0; mem_ready = 1;
        @(negedge clk);
        chk("to_mval", 32'(mem_valid), 32'd1);
        cyc();
        mem_ready = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("to_w%0d_v0", i), 32'(p0_resp_valid), 32'd0);
            cyc();
        end
        @(negedge clk);
        chk("to_v0", 32'(p0_resp_valid), 32'd1);
        chk("to_e0", 32'(p0_resp_err), 32'd1);
        chk("to_rdata", resp_rdata, 32'h0);
        chk("to_v1", 32'(p1_resp_valid), 32'd0);
        cyc();
        mem_rvalid = 1; mem_rdata = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_resp($sformatf("stray%0d", i), 0, 0);
            cyc();
        end
        mem_rvalid = 0;
        @(negedge clk);
        chk("stray_rdata", resp_rdata, 32'h0);
        cyc();

        // completion on the same cycle the timeout would fire
        p0_req_valid = 1; p0_addr = 32'h44;
        @(negedge clk);
        chk("tie_rdy0", 32'(p0_req_ready), 32'd1);
        cyc();
        p0_req_valid = 0; mem_ready = 1;
        @(negedge clk);
        chk("tie_mval", 32'(mem_valid), 32'd1);
        cyc();
        mem_ready = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("tie_w%0d_v0", i), 32'(p0_resp_valid), 32'd0);
            cyc();
        end
        mem_rvalid = 1; mem_rdata = 32'h600D;
        @(negedge clk);
        chk("tie_w7_v0", 32'(p0_resp_valid), 32'd0);
        cyc();
        mem_rvalid = 0;
        @(negedge clk);
        chk("tie_v0", 32'(p0_resp_valid), 32'd1);
        chk("tie_e0", 32'(p0_resp_err), 32'd0);
        chk("tie_rdata", resp_rdata, 32'h600D);
        cyc();

        // reset while in WAIT
        p0_req_valid = 1; p0_addr = 32'h48; p0_wen = 1;
        p0_wdata = 32'h1111; p0_wmask = 4'hF;
        @(negedge clk);
        chk("rw_rdy0", 32'(p0_req_ready), 32'd1);
        cyc();
        p0_req_valid = 0; mem_ready = 1;
        @(negedge clk);
        cyc();
        mem_ready = 0;
        @(negedge clk);
        chk("rw_wait_mval", 32'(mem_valid), 32'd0);
        cyc();
        rst = 0;
        @(negedge clk);
        cyc();
        rst = 1; mem_rvalid = 1; mem_rdata = 32'h77;
        @(negedge clk);
        chk("rw_mval", 32'(mem_valid), 32'd0);
        chk("rw_addr", mem_addr, 32'h0);
        chk("rw_wen", 32'(mem_wen), 32'd0);
        chk("rw_wdata", mem_wdata, 32'h0);
        chk("rw_wmask", 32'(mem_wmask), 32'h0);
        chk("rw_rdata", resp_rdata, 32'h0);
        chk("rw_e0", 32'(p0_resp_err), 32'd0);
        chk_resp("rw0", 0, 0);
        for (int i = 1; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk_resp($sformatf("rw%0d", i), 0, 0);
        end
        cyc();
        mem_rvalid = 0;
        p0_req_valid = 1; p1_req_valid = 1;
        @(negedge clk);
        chk("rw_tie_rdy0", 32'(p0_req_ready), 32'd1);
        chk("rw_tie_rdy1", 32'(p1_req_ready), 32'd0);
        cyc();
        p0_req_valid = 0; p1_req_valid = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
